// File: rtl/ysyx_041461_lsu_axi_master.sv
// rtl/ysyx_041461_lsu_axi_master.sv - single-beat AXI4 initiator for the LSU data port
// Optional misalign trap: define YSYX_041461_LSU_MISALIGN_CHECK_EN.
module ysyx_041461_lsu_axi_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic [7:0]  awlen,
    output logic        wvalid,
    input  logic        wready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RRESP,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;
    logic        misalign;

`ifdef YSYX_041461_LSU_MISALIGN_CHECK_EN
    assign misalign = (req_size > 3'd3) ||
                      ((req_addr & ((32'd1 << req_size) - 32'd1)) != 32'd0);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    size_d    = req_size;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = misalign;
                    if (misalign)    state_d = S_DONE;
                    else if (req_we) state_d = S_WRITE;
                    else             state_d = S_READ;
                end
            end
            S_WRITE: begin
                // AW and W complete independently; leave once both flags are set
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (arready) state_d = S_RRESP;
            end
            S_RRESP: begin
                if (rvalid) begin
                    rdata_d = rdata;
                    err_d   = (rresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_WRITE: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            S_WRESP: bready    = 1'b1;
            S_READ:  arvalid   = 1'b1;
            S_RRESP: rready    = 1'b1;
            S_DONE:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign awaddr    = addr_q;
    assign awsize    = size_q;
    assign awlen     = 8'd0;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wlast     = 1'b1;
    assign araddr    = addr_q;
    assign arsize    = size_q;
    assign arlen     = 8'd0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
